// File: rtl/bcd_mod_counter.sv
// Two-digit BCD up/down counter, modulo MODULO, with prescaled enable,
// synchronous clear and a range-checked parallel load. The digits always
// hold legal BCD codes and a value below MODULO, so a downstream
// BCD-to-decimal decoder always sees exactly one valid code.
module bcd_mod_counter #(
  parameter int MODULO   = 100,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_tens,
  input  logic [3:0] ld_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       step,
  output logic       tc,
  output logic       ld_err
);

  // Prescaler width; PRESCALE=1 still gets a 1-bit register that stays 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  // Digits of the top count value (MODULO-1), fixed at elaboration.
  localparam logic [3:0] MAX_T = 4'((MODULO - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MODULO - 1) % 10);

  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          step_q, step_d;
  logic          tc_q, tc_d;
  logic          err_q, err_d;
  logic [8:0]    nxt;

  // One decimal step with per-digit carry/borrow; returns {wrap, tens, ones}.
  function automatic logic [8:0] bcd_next(input logic [3:0] t, input logic [3:0] o,
                                          input logic dir);
    logic [8:0] r;
    r = {1'b0, t, o};
    if (dir) begin
      if (t == MAX_T && o == MAX_O) r = {1'b1, 4'd0, 4'd0};
      else if (o == 4'd9)           r = {1'b0, t + 4'd1, 4'd0};
      else                          r = {1'b0, t, o + 4'd1};
    end else begin
      if (t == 4'd0 && o == 4'd0)   r = {1'b1, MAX_T, MAX_O};
      else if (o == 4'd0)           r = {1'b0, t - 4'd1, 4'd9};
      else                          r = {1'b0, t, o - 4'd1};
    end
    return r;
  endfunction

  // A load is legal only if both digits are BCD and the value is below MODULO,
  // compared digit-wise against the MODULO-1 constants.
  function automatic logic load_ok(input logic [3:0] t, input logic [3:0] o);
    logic ok;
    ok = (t <= 4'd9) && (o <= 4'd9) &&
         ((t < MAX_T) || (t == MAX_T && o <= MAX_O));
    return ok;
  endfunction

  assign nxt = bcd_next(tens_q, ones_q, up);

  // Next-state: clr over load over count step over hold.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    pre_d  = pre_q;
    step_d = 1'b0;
    tc_d   = 1'b0;
    err_d  = 1'b0;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
      pre_d  = '0;
    end else if (load) begin
      if (load_ok(ld_tens, ld_ones)) begin
        tens_d = ld_tens;
        ones_d = ld_ones;
        pre_d  = '0;
      end else begin
        err_d  = 1'b1;
      end
    end else if (en) begin
      if (pre_q == PRE_LAST) begin
        pre_d  = '0;
        step_d = 1'b1;
        tc_d   = nxt[8];
        tens_d = nxt[7:4];
        ones_d = nxt[3:0];
      end else begin
        pre_d  = pre_q + PW'(1);
      end
    end
  end

  // State and strobe registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      pre_q  <= '0;
      step_q <= 1'b0;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
      pre_q  <= pre_d;
      step_q <= step_d;
      tc_q   <= tc_d;
      err_q  <= err_d;
    end
  end

  assign tens   = tens_q;
  assign ones   = ones_q;
  assign step   = step_q;
  assign tc     = tc_q;
  assign ld_err = err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: four instances with different MODULO/PRESCALE
// share one stimulus stream; a behavioural model per instance pushes the
// expected outputs to a queue and they are popped after each clock edge.
module tb_bcd_mod_counter;

  localparam int N = 4;
  localparam int MOD [N] = '{100, 100, 60, 2};
  localparam int PRE [N] = '{1, 4, 1, 1};

  typedef struct {
    logic [7:0] val;
    logic [2:0] flg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] ld_tens = 4'd0, ld_ones = 4'd0;
  logic [3:0] tn [N];
  logic [3:0] on [N];
  logic       st [N];
  logic       tcw [N];
  logic       er [N];

  int   mval [N];
  int   mpre [N];
  exp_t sb [$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MODULO(100), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tn[0]), .ones(on[0]),
    .step(st[0]), .tc(tcw[0]), .ld_err(er[0]));
  bcd_mod_counter #(.MODULO(100), .PRESCALE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tn[1]), .ones(on[1]),
    .step(st[1]), .tc(tcw[1]), .ld_err(er[1]));
  bcd_mod_counter #(.MODULO(60), .PRESCALE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tn[2]), .ones(on[2]),
    .step(st[2]), .tc(tcw[2]), .ld_err(er[2]));
  bcd_mod_counter #(.MODULO(2), .PRESCALE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tn[3]), .ones(on[3]),
    .step(st[3]), .tc(tcw[3]), .ld_err(er[3]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int obs_val(input int i);
    return int'({tn[i], on[i]});
  endfunction

  function automatic int obs_flg(input int i);
    return int'({st[i], tcw[i], er[i]});
  endfunction

  // Drive one cycle of stimulus, predict every instance, then compare.
  task automatic cyc(input logic c_en, input logic c_up, input logic c_clr,
                     input logic c_load, input int lt, input int lo);
    exp_t e;
    en = c_en; up = c_up; clr = c_clr; load = c_load;
    ld_tens = 4'(lt); ld_ones = 4'(lo);
    for (int i = 0; i < N; i++) begin
      logic s, c, r;
      s = 1'b0; c = 1'b0; r = 1'b0;
      if (c_clr) begin
        mval[i] = 0; mpre[i] = 0;
      end else if (c_load) begin
        if (lt <= 9 && lo <= 9 && (10 * lt + lo) < MOD[i]) begin
          mval[i] = 10 * lt + lo; mpre[i] = 0;
        end else r = 1'b1;
      end else if (c_en) begin
        if (mpre[i] == PRE[i] - 1) begin
          mpre[i] = 0; s = 1'b1;
          if (c_up) begin
            if (mval[i] == MOD[i] - 1) begin mval[i] = 0; c = 1'b1; end
            else mval[i] = mval[i] + 1;
          end else begin
            if (mval[i] == 0) begin mval[i] = MOD[i] - 1; c = 1'b1; end
            else mval[i] = mval[i] - 1;
          end
        end else mpre[i] = mpre[i] + 1;
      end
      e.val = to_bcd(mval[i]);
      e.flg = {s, c, r};
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      e = sb.pop_front();
      chk($sformatf("u%0d.value", i), obs_val(i), int'(e.val));
      chk($sformatf("u%0d.flags", i), obs_flg(i), int'(e.flg));
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.u%0d.value", tag, i), obs_val(i), 0);
      chk($sformatf("%s.u%0d.flags", tag, i), obs_flg(i), 0);
    end
  endtask

  initial begin
    int tcnt;
    for (int i = 0; i < N; i++) begin mval[i] = 0; mpre[i] = 0; end

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // Full up count through 99 -> 00
    tcnt = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1, 1, 0, 0, 0, 0);
      if (tcw[0]) tcnt++;
    end
    chk("a.tc_once", tcnt, 1);

    // Down count with wrap, then from a loaded 20
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("a.down_wrap", obs_val(0), 8'h99);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("a.down_18", obs_val(0), 8'h18);

    // Prescaler with en gaps
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("b.no_step_yet", int'(st[1]), 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("b.first_step", obs_val(1), 8'h01);
    cyc(0, 1, 0, 0, 0, 0);
    chk("b.step_one_cycle", int'(st[1]), 0);

    // Load checking against each MODULO
    cyc(0, 1, 0, 1, 5, 9);
    chk("c.load59", obs_val(2), 8'h59);
    chk("d.load59_err", int'(er[3]), 1);
    cyc(0, 1, 0, 1, 6, 0);
    chk("c.load60_err", int'(er[2]), 1);
    chk("c.stays59", obs_val(2), 8'h59);
    cyc(0, 1, 0, 1, 1, 10);
    chk("a.load_1_10_err", int'(er[0]), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("c.wrap_tc", int'(tcw[2]), 1);

    // Priority: clr over load, load over step
    cyc(1, 1, 1, 1, 4, 2);
    cyc(1, 1, 1, 1, 12, 12);
    chk("a.clr_no_err", int'(er[0]), 0);
    cyc(1, 1, 0, 1, 4, 2);
    chk("a.load_over_step", int'(st[0]), 0);

    // Back-to-back wraps on MODULO=2
    cyc(0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a cycle at value 37
    cyc(0, 1, 0, 1, 3, 7);
    en = 1'b1; up = 1'b1; load = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    for (int i = 0; i < N; i++) begin mval[i] = 0; mpre[i] = 0; end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0, 0, 0);

    // Mixed random traffic
    for (int k = 0; k < 300; k++) begin
      logic r_clr, r_load;
      r_clr  = ($urandom_range(0, 15) == 0);
      r_load = ($urandom_range(0, 7) == 0);
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
          r_clr, r_load, int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
